// File: rtl/key_rev_lookup.sv
// key_rev_lookup: runtime-writable key/data table with a sequential reverse
// search. Given a data value, returns the key of the lowest-index valid entry
// holding it. One entry is examined per clock between a valid/ready request
// port and a valid/ready response port.

// One table entry: {valid, key, data}. A clear beats a write in the same cycle.
module kr_entry #(
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_i,
  input  logic                clr_i,
  input  logic [KEY_LEN-1:0]  key_i,
  input  logic [DATA_LEN-1:0] data_i,
  output logic                valid_o,
  output logic [KEY_LEN-1:0]  key_o,
  output logic [DATA_LEN-1:0] data_o
);
  logic                valid_q;
  logic [KEY_LEN-1:0]  key_q;
  logic [DATA_LEN-1:0] data_q;

  // Entry storage; only the valid bit matters after reset or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      key_q   <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      key_q   <= key_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign key_o   = key_q;
  assign data_o  = data_q;
endmodule

module key_rev_lookup #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8,
  localparam int IDX_W   = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [KEY_LEN-1:0]  rsp_key,
  output logic                rsp_hit,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q;
  logic [DATA_LEN-1:0]                query_q;
  logic [KEY_LEN-1:0]                 rsp_key_q;
  logic                               rsp_hit_q;

  logic [NR_KEY-1:0]                  ent_vld;
  logic [NR_KEY-1:0][KEY_LEN-1:0]     ent_key;
  logic [NR_KEY-1:0][DATA_LEN-1:0]    ent_data;

  logic                               cur_match;
  logic                               last_idx;

  // Table: entry i decodes its own write strobe, so out-of-range wr_idx
  // values simply select no entry.
  for (genvar i = 0; i < NR_KEY; i++) begin : g_ent
    kr_entry #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (wr_en && (wr_idx == IDX_W'(i))),
      .clr_i   (clr),
      .key_i   (wr_key),
      .data_i  (wr_data),
      .valid_o (ent_vld[i]),
      .key_o   (ent_key[i]),
      .data_o  (ent_data[i])
    );
  end

  // Compare uses registered table contents, so a same-edge write is not seen.
  assign cur_match = ent_vld[idx_q] && (ent_data[idx_q] == query_q);
  assign last_idx  = (idx_q == IDX_W'(NR_KEY - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)              state_d = SCAN;
      SCAN:    if (cur_match || last_idx)  state_d = RESP;
      RESP:    if (rsp_ready)              state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Outputs are pure state decodes; the result fields come from registers.
  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q == SCAN);
    rsp_valid = (state_q == RESP);
    rsp_key   = rsp_key_q;
    rsp_hit   = rsp_hit_q;
  end

  // Search datapath: query capture, scan index, and result capture. The
  // result is only written in SCAN, so it stays frozen through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      query_q   <= '0;
      rsp_key_q <= '0;
      rsp_hit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          query_q <= req_data;
          idx_q   <= '0;
        end
        SCAN: begin
          if (cur_match) begin
            rsp_key_q <= ent_key[idx_q];
            rsp_hit_q <= 1'b1;
          end else if (last_idx) begin
            rsp_key_q <= '0;
            rsp_hit_q <= 1'b0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_key_rev_lookup.sv
// Scoreboard bench for key_rev_lookup: the driver pushes the expected result
// of each search from a behavioural table model; a negedge monitor pops and
// compares when rsp_valid rises and checks stability while stalled.
module tb_key_rev_lookup;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, clr, req_valid, rsp_ready;
  logic [1:0] wr_idx, wr_key;
  logic [7:0] wr_data, req_data;
  logic       req_ready, rsp_valid, rsp_hit, busy;
  logic [1:0] rsp_key;

  // Second instance with NR_KEY=3 for the out-of-range write case.
  logic       b_wr_en, b_clr, b_req_valid, b_rsp_ready;
  logic [1:0] b_wr_idx, b_wr_key;
  logic [7:0] b_wr_data, b_req_data;
  logic       b_req_ready, b_rsp_valid, b_rsp_hit, b_busy;
  logic [1:0] b_rsp_key;

  always #5 clk = ~clk;

  key_rev_lookup #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_key(rsp_key), .rsp_hit(rsp_hit), .busy(busy));

  key_rev_lookup #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_key(b_wr_key),
    .wr_data(b_wr_data), .clr(b_clr), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_data(b_req_data), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_key(b_rsp_key), .rsp_hit(b_rsp_hit), .busy(b_busy));

  typedef struct {
    logic       hit;
    logic [1:0] key;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  // Behavioural table model.
  bit         mv[N];
  logic [1:0] mk[N];
  logic [7:0] md[N];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Lowest valid index holding q wins; entry k is looked at k+1 cycles in.
  function automatic exp_t model_search(input logic [7:0] q);
    exp_t e;
    e.hit = 1'b0; e.key = 2'd0; e.lat = N;
    for (int i = 0; i < N; i++) begin
      if (mv[i] && md[i] == q) begin
        e.hit = 1'b1; e.key = mk[i]; e.lat = i + 1;
        return e;
      end
    end
    return e;
  endfunction

  // Acceptance tracking (pre-edge values are seen here).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && req_valid && req_ready) acc_cyc = cyc;
  end

  // Monitor: compare on rsp_valid rise, then check the response holds.
  bit         in_resp = 1'b0;
  logic [1:0] held_key;
  logic       held_hit;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 1'b0;
    end else if (rsp_valid && !in_resp) begin
      exp_t e;
      in_resp = 1'b1;
      if (sb.size() == 0) begin
        chk("sb_unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_hit", int'(rsp_hit), int'(e.hit));
        chk("rsp_key", int'(rsp_key), int'(e.key));
        chk("rsp_latency", cyc - acc_cyc, e.lat);
      end
      held_key = rsp_key;
      held_hit = rsp_hit;
    end else if (rsp_valid) begin
      chk("stall_key", int'(rsp_key), int'(held_key));
      chk("stall_hit", int'(rsp_hit), int'(held_hit));
      chk("stall_req_ready", int'(req_ready), 0);
    end else begin
      in_resp = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive a write for the coming edge and mirror it in the model.
  task automatic drive_write(input logic [1:0] idx, input logic [1:0] k, input logic [7:0] d);
    wr_en = 1'b1; wr_idx = idx; wr_key = k; wr_data = d;
    mv[idx] = 1'b1; mk[idx] = k; md[idx] = d;
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [1:0] k, input logic [7:0] d);
    drive_write(idx, k, d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    step();
    clr = 1'b0;
  endtask

  // Wait for the response, stall it, then handshake.
  // mode 0: quiet stall; 1: random writes; 2: overwrite entry 2.
  task automatic wait_resp(input int stall, input int mode);
    int n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    for (int s = 0; s < stall; s++) begin
      if (mode == 1 && $urandom_range(0, 1) == 1)
        drive_write(2'($urandom_range(0, 3)), 2'($urandom), 8'h10 + 8'($urandom_range(0, 3)));
      else if (mode == 2)
        drive_write(2'd2, 2'd0, 8'hEE);
      step();
      wr_en = 1'b0;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("req_ready_after_hs", int'(req_ready), 1);
  endtask

  task automatic issue(input logic [7:0] q);
    req_valid = 1'b1; req_data = q;
    sb.push_back(model_search(q));
    step();
    req_valid = 1'b0; req_data = 8'($urandom);
  endtask

  task automatic search(input logic [7:0] q, input int stall, input int mode);
    issue(q);
    wait_resp(stall, mode);
  endtask

  task automatic b_search(input logic [7:0] q, input logic hit, input logic [1:0] k);
    int n = 0;
    b_req_valid = 1'b1; b_req_data = q;
    step();
    b_req_valid = 1'b0;
    while (!b_rsp_valid && n < 20) begin step(); n++; end
    chk("b_latency", n, 3);
    chk("b_rsp_hit", int'(b_rsp_hit), int'(hit));
    chk("b_rsp_key", int'(b_rsp_key), int'(k));
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    wr_en = 0; clr = 0; req_valid = 0; rsp_ready = 0;
    wr_idx = 0; wr_key = 0; wr_data = 0; req_data = 0;
    b_wr_en = 0; b_clr = 0; b_req_valid = 0; b_rsp_ready = 0;
    b_wr_idx = 0; b_wr_key = 0; b_wr_data = 0; b_req_data = 0;
    for (int i = 0; i < N; i++) begin mv[i] = 0; mk[i] = 0; md[i] = 0; end

    #2;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_key", int'(rsp_key), 0);
    chk("rst_rsp_hit", int'(rsp_hit), 0);
    step();
    rst_n = 1'b1;
    step();

    // Empty table: miss after 4 cycles.
    search(8'h00, 0, 0);

    // Hit latency and lowest-index priority.
    do_write(2'd0, 2'd3, 8'hA5);
    do_write(2'd2, 2'd1, 8'h3C);
    do_write(2'd3, 2'd2, 8'h3C);
    search(8'h3C, 0, 0);
    search(8'hA5, 0, 0);

    // Backpressure with an overwrite of the matched entry while stalled.
    search(8'h3C, 5, 2);
    search(8'hEE, 0, 0);

    // Write lands on the same edge that compares idx1: old contents used.
    do_clr();
    req_valid = 1'b1; req_data = 8'h77;
    e.hit = 1'b0; e.key = 2'd0; e.lat = 4;
    sb.push_back(e);
    step();                       // E0 accept
    req_valid = 1'b0;
    step();                       // E1 compares idx0
    drive_write(2'd1, 2'd0, 8'h77);
    step();                       // E2 compares idx1 and writes it
    wr_en = 1'b0;
    wait_resp(0, 0);
    search(8'h77, 0, 0);          // now visible: hit at idx1

    // clr and wr_en together: clear wins.
    do_write(2'd0, 2'd1, 8'h55);
    clr = 1'b1; wr_en = 1'b1; wr_idx = 2'd3; wr_key = 2'd2; wr_data = 8'h55;
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    step();
    clr = 1'b0; wr_en = 1'b0;
    search(8'h55, 0, 0);
    search(8'h77, 0, 0);

    // Reset mid-search aborts and clears the table.
    do_write(2'd3, 2'd2, 8'hA5);
    issue(8'hA5);
    step();
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", int'(req_ready), 1);
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rsp_key", int'(rsp_key), 0);
    chk("mid_rst_rsp_hit", int'(rsp_hit), 0);
    sb.delete();
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    search(8'hA5, 0, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      int nw = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) do_clr();
      for (int w = 0; w < nw; w++)
        do_write(2'($urandom_range(0, 3)), 2'($urandom), 8'h10 + 8'($urandom_range(0, 3)));
      search(8'h10 + 8'($urandom_range(0, 4)), $urandom_range(0, 3), 1);
    end

    // NR_KEY=3: wr_idx=3 is ignored; a real entry still hits.
    b_wr_en = 1'b1; b_wr_idx = 2'd3; b_wr_key = 2'd1; b_wr_data = 8'h99;
    step();
    b_wr_en = 1'b0;
    b_search(8'h99, 1'b0, 2'd0);
    b_wr_en = 1'b1; b_wr_idx = 2'd2; b_wr_key = 2'd2; b_wr_data = 8'h99;
    step();
    b_wr_en = 1'b0;
    b_search(8'h99, 1'b1, 2'd2);

    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
